// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl
// Description : Bimodal branch predictor and EX-stage redirect control.
//               A table of 2^INDEX_BITS two-bit saturating counters supplies
//               a zero-latency taken prediction for the fetch PC. When a
//               conditional branch resolves in EX, its counter is trained,
//               a mispredict raises redirect/flush requests, and the
//               branch/mispredict statistics are updated.
// Ports       :
//   CPU_CLK          in   clock, rising-edge
//   CPU_RST          in   synchronous active-high reset
//   PCF[31:0]        in   fetch-stage PC
//   PredTakenF       out  taken prediction for PCF
//   BranchTypeE[2:0] in   EX branch type, 0 = not a conditional branch
//   PCE[31:0]        in   EX-stage PC
//   PredTakenE       in   prediction that travelled with the EX instruction
//   BranchJumpE      in   resolved branch outcome
//   StallE           in   EX stage held this cycle
//   StatClr          in   clear statistics counters
//   FlushD           out  squash IF/ID
//   FlushE           out  squash ID/EX
//   RedirectE        out  replace next PC with corrected PC
//   RedirectToTarget out  1 = target, 0 = PCE+4
//   BranchCount      out  resolved conditional branches (saturating)
//   MispredCount     out  mispredicted branches (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    input  logic [2:0]  BranchTypeE,
    input  logic [31:0] PCE,
    input  logic        PredTakenE,
    input  logic        BranchJumpE,
    input  logic        StallE,
    input  logic        StatClr,
    output logic        FlushD,
    output logic        FlushE,
    output logic        RedirectE,
    output logic        RedirectToTarget,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam int          ENTRIES  = 1 << INDEX_BITS;
    localparam logic [2:0]  NOBRANCH = 3'd0;
    localparam logic [1:0]  CNT_MAX  = 2'b11;
    localparam logic [1:0]  CNT_MIN  = 2'b00;
    localparam logic [1:0]  CNT_INIT = 2'b01;
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    logic [1:0]            r_bht [ENTRIES];
    logic [31:0]           r_branch_cnt;
    logic [31:0]           r_mispred_cnt;

    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [INDEX_BITS-1:0] w_wr_idx;
    logic                  w_resolve;
    logic                  w_mispred;
    logic [1:0]            w_cur_cnt;
    logic                  w_unused_pc_bits;

    // No tags: upper PC bits alias onto the same counter.
    assign w_rd_idx = PCF[INDEX_BITS+1:2];
    assign w_wr_idx = PCE[INDEX_BITS+1:2];
    assign w_unused_pc_bits = ^{PCF[31:INDEX_BITS+2], PCF[1:0],
                                PCE[31:INDEX_BITS+2], PCE[1:0]};

    // Read is asynchronous from the array, so a same-cycle update to the
    // same index is seen only after the edge.
    assign PredTakenF = r_bht[w_rd_idx][1];

    // Reset gates resolution so nothing redirects or trains in a reset cycle.
    assign w_resolve = (BranchTypeE != NOBRANCH) & ~StallE & ~CPU_RST;
    assign w_mispred = w_resolve & (PredTakenE != BranchJumpE);

    assign RedirectE        = w_mispred;
    assign FlushD           = w_mispred;
    assign FlushE           = w_mispred;
    assign RedirectToTarget = w_mispred & BranchJumpE;

    assign w_cur_cnt    = r_bht[w_wr_idx];
    assign BranchCount  = r_branch_cnt;
    assign MispredCount = r_mispred_cnt;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= CNT_INIT;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve) begin
                if (BranchJumpE) begin
                    if (w_cur_cnt != CNT_MAX) begin
                        r_bht[w_wr_idx] <= w_cur_cnt + 2'b01;
                    end
                end else begin
                    if (w_cur_cnt != CNT_MIN) begin
                        r_bht[w_wr_idx] <= w_cur_cnt - 2'b01;
                    end
                end
            end

            // Clear wins over a same-cycle increment.
            if (StatClr) begin
                r_branch_cnt  <= '0;
                r_mispred_cnt <= '0;
            end else begin
                if (w_resolve && (r_branch_cnt != STAT_MAX)) begin
                    r_branch_cnt <= r_branch_cnt + 32'd1;
                end
                if (w_mispred && (r_mispred_cnt != STAT_MAX)) begin
                    r_mispred_cnt <= r_mispred_cnt + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_ctrl
// Description : Self-checking bench for branch_predict_ctrl. Directed
//               scenarios followed by random traffic, all compared against
//               an integer-counter reference model of the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pcf;
    logic        pred_f;
    logic [2:0]  btype;
    logic [31:0] pce;
    logic        pred_e;
    logic        bj;
    logic        stall;
    logic        clr;
    logic        flush_d;
    logic        flush_e;
    logic        redir;
    logic        redir_tgt;
    logic [31:0] bcount;
    logic [31:0] mcount;

    int checks;
    int errors;

    // Reference model: counter value 0..3 per entry, taken when >= 2.
    int          m_bht [16];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    branch_predict_ctrl #(.INDEX_BITS(4)) dut (
        .CPU_CLK          (clk),
        .CPU_RST          (rst),
        .PCF              (pcf),
        .PredTakenF       (pred_f),
        .BranchTypeE      (btype),
        .PCE              (pce),
        .PredTakenE       (pred_e),
        .BranchJumpE      (bj),
        .StallE           (stall),
        .StatClr          (clr),
        .FlushD           (flush_d),
        .FlushE           (flush_e),
        .RedirectE        (redir),
        .RedirectToTarget (redir_tgt),
        .BranchCount      (bcount),
        .MispredCount     (mcount)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        return (m_bht[idx(pc)] >= 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] f, input logic [2:0] t,
                         input logic [31:0] e, input logic pe, input logic j,
                         input logic s, input logic c);
        rst = r; pcf = f; btype = t; pce = e; pred_e = pe; bj = j; stall = s; clr = c;
    endtask

    // Checks combinational outputs mid-cycle, clocks once, updates the model,
    // then checks the statistics registers.
    task automatic cycle();
        logic res;
        logic mis;
        int   k;
        #20;
        res = (btype != 3'd0) && !stall && !rst;
        mis = res && (pred_e != bj);
        chk("PredTakenF", {31'd0, pred_f}, {31'd0, model_pred(pcf)});
        chk("FlushD", {31'd0, flush_d}, {31'd0, mis});
        chk("FlushE", {31'd0, flush_e}, {31'd0, mis});
        chk("RedirectE", {31'd0, redir}, {31'd0, mis});
        chk("RedirectToTarget", {31'd0, redir_tgt}, {31'd0, mis && bj});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (res) begin
                k = idx(pce);
                if (bj) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
                else    m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
            end
            if (clr) begin
                m_bc = 0;
                m_mc = 0;
            end else begin
                if (res && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
                if (mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
            end
        end
        #1;
        chk("BranchCount", bcount, m_bc);
        chk("MispredCount", mcount, m_mc);
    endtask

    // Every fetch index predicts not-taken; run within one cycle.
    task automatic sweep_not_taken(input string tag);
        for (int i = 0; i < 16; i++) begin
            pcf = 32'(i * 4);
            #2;
            chk(tag, {31'd0, pred_f}, 32'd0);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
        // Unchecked first reset to bring the table out of X.
        drive(1'b1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset cycle checked, then the first cycle after reset predicts NT.
        do_reset();
        chk("reset_BranchCount", bcount, 32'd0);
        chk("reset_MispredCount", mcount, 32'd0);
        sweep_not_taken("post_reset_pred");

        // BEQ at 0x40 taken four times, prediction carried from fetch.
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 32'h40, 3'd1, 32'h40, model_pred(32'h40), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h40, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #20;
        chk("beq_pred_0x40", {31'd0, pred_f}, 32'd1);
        chk("beq_branch_count", bcount, 32'd4);
        chk("beq_mispred_count", mcount, 32'd1);
        @(posedge clk);
        #1;

        // Counter at 0x80 reaches 11, then BNE resolves not-taken.
        do_reset();
        for (int n = 0; n < 2; n++) begin
            drive(1'b0, 32'h80, 3'd2, 32'h80, model_pred(32'h80), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h80, 3'd2, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        #20;
        chk("bne_redirect", {29'd0, redir, flush_d, flush_e}, 32'd7);
        chk("bne_to_target", {31'd0, redir_tgt}, 32'd0);
        @(posedge clk);
        #1;
        m_bht[idx(32'h80)] = 2;
        m_bc = m_bc + 1;
        m_mc = m_mc + 1;
        drive(1'b0, 32'h80, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        // Counter now 10: one more not-taken drops prediction to NT.
        drive(1'b0, 32'h80, 3'd2, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h80, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();

        // Mispredicted branch held by stall for three cycles, then released.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 32'h8, 3'd1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h8, 3'd1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("stall_single_count", bcount, 32'd1);

        // Same-index read and update: old value this cycle, new value next.
        do_reset();
        drive(1'b0, 32'h100, 3'd1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        #20;
        chk("bypass_old_value", {31'd0, pred_f}, 32'd0);
        @(posedge clk);
        #1;
        m_bht[idx(32'h100)] = 2;
        m_bc = m_bc + 1;
        m_mc = m_mc + 1;
        drive(1'b0, 32'h100, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #20;
        chk("bypass_new_value", {31'd0, pred_f}, 32'd1);
        @(posedge clk);
        #1;

        // Mispredict counter saturation, then clear beats a resolve.
        do_reset();
        force dut.r_mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_mispred_cnt;
        m_mc = 32'hFFFF_FFFF;
        drive(1'b0, 32'h0, 3'd1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("mispred_saturated", mcount, 32'hFFFF_FFFF);
        drive(1'b0, 32'h0, 3'd1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("statclr_branch", bcount, 32'd0);
        chk("statclr_mispred", mcount, 32'd0);

        // Reset during a mispredict cycle.
        drive(1'b0, 32'h0, 3'd1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h0, 3'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        #20;
        chk("rst_no_redirect", {28'd0, redir, flush_d, flush_e, redir_tgt}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_stats_zero", bcount | mcount, 32'd0);
        sweep_not_taken("rst_pred_01");

        // Random traffic over a narrow PC range so indices collide often.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] f;
            logic [31:0] e;
            logic [2:0]  t;
            f = {$urandom_range(0, 127), 2'b00};
            e = {$urandom_range(0, 127), 2'b00};
            t = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            drive(($urandom_range(0, 99) == 0),
                  f, t, e,
                  ($urandom_range(0, 3) == 0) ? 1'($urandom) : model_pred(e),
                  1'($urandom),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 49) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
